// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate-cell self-test sequencer.
//   - Gate type encodings carried on gate_sel.
//   - Sequencer state encoding.
//   - Truth-table vector order: bit idx of each table is the a/b value
//     driven for vector idx, giving (0,0), (0,1), (1,0), (1,1).
package gate_seq_pkg;

    localparam logic [2:0] GATE_AND  = 3'd0;
    localparam logic [2:0] GATE_OR   = 3'd1;
    localparam logic [2:0] GATE_NAND = 3'd2;
    localparam logic [2:0] GATE_NOR  = 3'd3;
    localparam logic [2:0] GATE_XOR  = 3'd4;
    localparam logic [2:0] GATE_XNOR = 3'd5;
    localparam logic [2:0] GATE_BUF  = 3'd6;
    localparam logic [2:0] GATE_INV  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [3:0] VEC_A_TABLE = 4'b1100;
    localparam logic [3:0] VEC_B_TABLE = 4'b1010;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for the 2-input gate cells.
// Ports:
//   gate_sel - gate type (see gate_seq_pkg encodings)
//   a, b     - gate inputs
//   c        - expected gate output
// BUF and INV ignore b.
module gate_ref_model
    import gate_seq_pkg::*;
(
    input  logic [2:0] gate_sel,
    input  logic       a,
    input  logic       b,
    output logic       c
);

    // NOTE: assign a default before the case so every path drives c;
    // a path that leaves it unassigned would infer a latch.
    always_comb begin
        c = 1'b0;
        case (gate_sel)
            GATE_AND:  c = a & b;
            GATE_OR:   c = a | b;
            GATE_NAND: c = ~(a & b);
            GATE_NOR:  c = ~(a | b);
            GATE_XOR:  c = a ^ b;
            GATE_XNOR: c = ~(a ^ b);
            GATE_BUF:  c = a;
            GATE_INV:  c = ~a;
            default:   c = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Self-test sequencer for one 2-input gate cell. On start it drives the four
// truth-table vectors into the external gate, waits SETTLE_CYCLES per vector,
// samples dut_c against the reference for the latched gate type and reports
// the result.
// Ports:
//   clk, rst       - clock; synchronous active-high reset
//   start          - one-cycle run request, honoured only in IDLE
//   gate_sel       - gate type, latched when start is accepted
//   dut_c          - output of the gate under test
//   dut_a, dut_b   - registered gate inputs
//   busy           - run in progress (APPLY through DONE)
//   done           - one-cycle pulse at the end of a run
//   pass           - last run had no mismatches
//   err_count      - saturating mismatch count of the last run
//   first_fail     - index of the first mismatching vector (when fail_seen)
//   fail_seen      - last run had at least one mismatch
module gate_vector_sequencer
    import gate_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       gate_sel,
    input  logic             dut_c,
    output logic             dut_a,
    output logic             dut_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_fail,
    output logic             fail_seen
);

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_t     state, state_next;
    logic [1:0] idx;
    logic [3:0] settle_cnt;
    logic [2:0] gate_q;
    logic       exp_c;
    logic       mismatch;

    gate_ref_model u_ref (
        .gate_sel (gate_q),
        .a        (dut_a),
        .b        (dut_b),
        .c        (exp_c)
    );

    // A non-clean dut_c makes the equality unknown; the if then falls
    // through and the default keeps mismatch set, so X/Z never matches.
    always_comb begin
        mismatch = 1'b1;
        if (dut_c == exp_c) mismatch = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (start) state_next = ST_APPLY;
            ST_APPLY:  state_next = ST_SETTLE;
            ST_SETTLE: if (settle_cnt <= 4'd1) state_next = ST_CHECK;
            ST_CHECK:  state_next = (idx == 2'd3) ? ST_DONE : ST_APPLY;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= 2'd0;
            fail_seen  <= 1'b0;
            idx        <= 2'd0;
            settle_cnt <= 4'd0;
            gate_q     <= 3'd0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        gate_q     <= gate_sel;
                        err_count  <= '0;
                        fail_seen  <= 1'b0;
                        first_fail <= 2'd0;
                        pass       <= 1'b0;
                        idx        <= 2'd0;
                    end
                end
                ST_APPLY: begin
                    dut_a      <= VEC_A_TABLE[idx];
                    dut_b      <= VEC_B_TABLE[idx];
                    settle_cnt <= SETTLE_LOAD;
                end
                ST_SETTLE: settle_cnt <= settle_cnt - 4'd1;
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
                        if (!fail_seen) begin
                            fail_seen  <= 1'b1;
                            first_fail <= idx;
                        end
                    end
                    if (idx != 2'd3) idx <= idx + 2'd1;
                end
                // err_count already holds the final CHECK update here.
                ST_DONE: pass <= (err_count == '0);
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Scoreboard bench: u_dut0 (ERR_W=3) and u_dut1 (ERR_W=2) run in lockstep,
// each driving its own modelled gate under test with optional faults.
module tb_gate_vector_sequencer;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] gate_sel = 3'd0;

    logic       dut_a0, dut_b0, dut_c0, busy0, done0, pass0, fail_seen0;
    logic [2:0] err0;
    logic [1:0] ff0;
    logic       dut_a1, dut_b1, dut_c1, busy1, done1, pass1, fail_seen1;
    logic [1:0] err1;
    logic [1:0] ff1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Truth tables, bit i = output for vector i ((a,b) = {i[1],i[0]}).
    logic [3:0] truth_tab [8] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                                  4'b0110, 4'b1001, 4'b1100, 4'b0011};

    // Gate-under-test fault configuration: 0 correct gate f_gate,
    // 1 stuck-at-0, 2 stuck-at-1, 3 X on vector f_xidx.
    int unsigned f_mode = 0;
    logic [2:0]  f_gate = 3'd0;
    logic [1:0]  f_xidx = 2'd0;
    logic        x_bit = 1'bx;

    typedef struct {
        int         done_cyc;
        logic [2:0] err0;
        logic [1:0] err1;
        logic       fs;
        logic [1:0] ff;
        logic       pass;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    bit   pend = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic gut_out(int unsigned mode, logic [2:0] g,
                                     logic [1:0] xi, logic [1:0] vidx);
        logic [3:0] row;
        row = truth_tab[g];
        if (mode == 1) return 1'b0;
        if (mode == 2) return 1'b1;
        if (mode == 3 && vidx == xi) return x_bit;
        return row[vidx];
    endfunction

    always_comb dut_c0 = gut_out(f_mode, f_gate, f_xidx, {dut_a0, dut_b0});
    always_comb dut_c1 = gut_out(f_mode, f_gate, f_xidx, {dut_a1, dut_b1});

    gate_vector_sequencer #(.SETTLE_CYCLES(S), .ERR_W(3)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel),
        .dut_c(dut_c0), .dut_a(dut_a0), .dut_b(dut_b0), .busy(busy0),
        .done(done0), .pass(pass0), .err_count(err0), .first_fail(ff0),
        .fail_seen(fail_seen0)
    );

    gate_vector_sequencer #(.SETTLE_CYCLES(S), .ERR_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel),
        .dut_c(dut_c1), .dut_a(dut_a1), .dut_b(dut_b1), .busy(busy1),
        .done(done1), .pass(pass1), .err_count(err1), .first_fail(ff1),
        .fail_seen(fail_seen1)
    );

    logic [2:0] r_sel;
    logic       r_a, r_b, r_c;
    gate_ref_model u_ref (.gate_sel(r_sel), .a(r_a), .b(r_b), .c(r_c));

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops on every done pulse, checks held results one cycle later.
    always @(negedge clk) begin
        if (pend) begin
            check("pass0", pass0, cur.pass);
            check("pass1", pass1, cur.pass);
            check("busy_after_done", busy0, 0);
            check("err0_held", err0, cur.err0);
            pend = 1'b0;
        end
        if (done0 || done1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", {done0, done1}, 0);
            end else begin
                cur = sb_q.pop_front();
                check("done_cycle", cyc, cur.done_cyc);
                check("done1_lockstep", done1, 1);
                check("busy_in_done", busy0, 1);
                check("err0", err0, cur.err0);
                check("err1_sat", err1, cur.err1);
                check("fail_seen0", fail_seen0, cur.fs);
                check("fail_seen1", fail_seen1, cur.fs);
                check("first_fail0", ff0, cur.ff);
                check("first_fail1", ff1, cur.ff);
                pend = 1'b1;
            end
        end
    end

    task automatic run_test(input logic [2:0] g, input int unsigned mode,
                            input logic [2:0] dg, input logic [1:0] xi,
                            input bit extra_start);
        exp_t e;
        int   n;
        logic v;
        logic [3:0] row;
        @(negedge clk);
        f_mode = mode; f_gate = dg; f_xidx = xi;
        gate_sel = g; start = 1'b1;
        row = truth_tab[g];
        n = 0; e.ff = 2'd0;
        for (int i = 0; i < 4; i++) begin
            v = gut_out(mode, dg, xi, 2'(i));
            if (v !== row[i]) begin
                if (n == 0) e.ff = 2'(i);
                n++;
            end
        end
        e.fs = (n > 0);
        e.err0 = 3'((n > 7) ? 7 : n);
        e.err1 = 2'((n > 3) ? 3 : n);
        e.pass = (n == 0);
        e.done_cyc = cyc + 1 + 4 * (S + 2);
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        gate_sel = 3'($urandom_range(0, 7));
        if (extra_start) begin
            repeat (4) @(negedge clk);
            start = 1'b1;
            gate_sel = ~g;
            @(negedge clk);
            start = 1'b0;
        end
        for (int t = 0; t < 100 && (sb_q.size() != 0 || pend); t++) @(negedge clk);
        check("run_completed", sb_q.size(), 0);
        check("hold_a", dut_a0, 1);
        check("hold_b", dut_b0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic abort_test();
        @(negedge clk);
        f_mode = 0; f_gate = 3'd2; gate_sel = 3'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_a", dut_a0, 0);
        check("abort_b", dut_b0, 0);
        check("abort_busy", busy0, 0);
        check("abort_done", done0, 0);
        check("abort_err", err0, 0);
        check("abort_fail_seen", fail_seen0, 0);
        check("abort_first_fail", ff0, 0);
        check("abort_pass", pass0, 0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_idle", busy0, 0);
    endtask

    initial begin
        for (int g = 0; g < 8; g++) begin
            for (int i = 0; i < 4; i++) begin
                logic [3:0] row;
                row = truth_tab[g];
                r_sel = 3'(g); r_a = i[1]; r_b = i[0];
                #1;
                check("ref_model", r_c, row[i]);
            end
        end

        repeat (3) @(negedge clk);
        check("rst_a", dut_a0, 0);
        check("rst_b", dut_b0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        check("rst_err", err0, 0);
        check("rst_first_fail", ff0, 0);
        check("rst_fail_seen", fail_seen0, 0);
        check("rst_busy1", busy1, 0);
        rst = 1'b0;

        run_test(3'd2, 0, 3'd2, 2'd0, 1'b0);   // correct NAND
        run_test(3'd2, 0, 3'd0, 2'd0, 1'b0);   // AND wired where NAND expected
        run_test(3'd2, 2, 3'd2, 2'd0, 1'b0);   // NAND stuck-at-1
        run_test(3'd2, 0, 3'd2, 2'd0, 1'b1);   // start re-pulsed mid-run
        for (int g = 0; g < 8; g++) run_test(3'(g), 0, 3'(g), 2'd0, 1'b0);
        run_test(3'd4, 3, 3'd4, 2'd1, 1'b0);   // XOR with X on vector 1
        abort_test();
        for (int r = 0; r < 16; r++) begin
            logic [2:0]  g, dg;
            int unsigned m;
            g = 3'($urandom_range(0, 7));
            m = $urandom_range(0, 3);
            dg = (m == 0 && $urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : g;
            run_test(g, m, dg, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
